serial_addsub: RTL and testbench

- Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop.
- Processes one bit per clock, LSB first, over WIDTH cycles, trading latency for area.
- Sits beside the datapath's combinational adders as the low-area arithmetic unit for multi-cycle operations; controlled by a start/busy/done handshake.

---
 rtl/serial_addsub.sv | 96 +++++++++
 tb/tb_serial_addsub.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// WIDTH cycles per operation under a start/busy/done handshake.

module serial_addsub_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CMSB_IDX = CW'(WIDTH - 2);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] ra, rb;
   logic             carry, cmsb;
   logic [CW-1:0]    cnt;
   logic             s_bit, c_bit;

   serial_addsub_fa u_fa (
      .a  (ra[0]),
      .b  (rb[0]),
      .ci (carry),
      .s  (s_bit),
      .co (c_bit)
   );

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ra       <= '0;
         rb       <= '0;
         carry    <= 1'b0;
         cmsb     <= 1'b0;
         cnt      <= '0;
         S        <= '0;
         Cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtract as A + ~B + 1: invert B up front, seed carry with 1.
                  ra    <= A;
                  rb    <= B ^ {WIDTH{sub}};
                  carry <= sub;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               S     <= {s_bit, S[WIDTH-1:1]};
               ra    <= ra >> 1;
               rb    <= rb >> 1;
               carry <= c_bit;
               cnt   <= cnt + 1'b1;
               if (cnt == CMSB_IDX)
                  cmsb <= c_bit;
               // Terminal compare precedes any wrap of cnt back to zero.
               if (cnt == LAST_IDX) begin
                  Cout     <= c_bit;
                  overflow <= cmsb ^ c_bit;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboarded bench for serial_addsub (WIDTH=8): directed vectors, handshake
// timing, busy rejection and asynchronous mid-operation reset.

module tb_serial_addsub;
   localparam int W = 8;

   logic         clk, rst, start, sub;
   logic [W-1:0] A, B;
   logic         busy, done;
   logic [W-1:0] S;
   logic         Cout, overflow;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      string        name;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   done_cnt = 0;

   serial_addsub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .S        (S),
      .Cout     (Cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 S=0x%0h expected no done", S);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_S"}, 32'(S), 32'(e.s));
            check({e.name, "_Cout"}, 32'(Cout), 32'(e.c));
            check({e.name, "_ovf"}, 32'(overflow), 32'(e.o));
         end
      end
   end

   task automatic push(input string name, input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.name = name; e.s = s; e.c = c; e.o = o;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b);
      sub = sb; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got busy=1 expected busy=0 within 40 cycles", name);
      end
   endtask

   task automatic op(input string name, input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] s, input logic c, input logic o);
      push(name, s, c, o);
      issue(sb, a, b);
      wait_idle(name);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_S", 32'(S), 0);
      check("rst_Cout", 32'(Cout), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      op("add_ovf",  1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
      op("add_wrap", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      op("sub_borr", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
      op("sub_ovf",  1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
      op("sub_zero", 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

      // Handshake: start accepted at edge 0; busy/done traced per edge.
      push("hs_main", 8'h03, 1'b0, 1'b0);
      issue(1'b0, 8'h01, 8'h02);
      check("hs_busy_e0", 32'(busy), 1);
      for (int e = 1; e <= 9; e++) begin
         if (e == 3) begin
            sub = 1'b1; A = 8'hFF; B = 8'hFF; start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (e == 5) begin
            A = 8'hAA; B = 8'h55; sub = 1'b1;
         end
         check($sformatf("hs_busy_e%0d", e), 32'(busy), (e <= 8) ? 1 : 0);
         check($sformatf("hs_done_e%0d", e), 32'(done), (e == 8) ? 1 : 0);
         if (e == 9) begin
            // Raised right after edge 9: must be taken at the next edge.
            push("hs_next", 8'h22, 1'b1, 1'b0);
            sub = 1'b1; A = 8'h33; B = 8'h11; start = 1'b1;
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("hs_next_accepted", 32'(busy), 1);
      wait_idle("hs_next");
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a run.
      issue(1'b0, 8'h12, 8'h34);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_S", 32'(S), 0);
      check("arst_Cout", 32'(Cout), 0);
      check("arst_ovf", 32'(overflow), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_done", 32'(done), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("arst_no_done_busy", 32'(busy), 0);

      op("post_rst", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

      check("done_pulses", 32'(done_cnt), 8);
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
